// File: rtl/exec_issue_ctrl.sv
// rtl/exec_issue_ctrl.sv - single-entry decode-to-execute issue controller
//
// Purpose: registers one instruction per accept, translates its 7-bit opcode
// into the ALU operation and control flags, sequences multi-cycle MUL/DIV,
// keeps the Z/N flags written by compares and resolves conditional branches.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        decode handshake; in_opcode, in_tag payload
//   out_valid                one-cycle issue pulse with out_aluop, out_use_imm,
//                            out_wb_en, out_mem_rd, out_mem_wr, out_is_branch,
//                            out_reg_target, out_take_branch, out_tag
//   alu_start                one-cycle launch pulse for MUL/DIV
//   cmp_z, cmp_n             ALU compare result during a CMP/CMPI issue
//   illegal                  one-cycle pulse for a consumed undefined opcode
module exec_issue_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       in_opcode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [5:0]       out_aluop,
    output logic             out_use_imm,
    output logic             out_wb_en,
    output logic             out_mem_rd,
    output logic             out_mem_wr,
    output logic             out_is_branch,
    output logic             out_reg_target,
    output logic             out_take_branch,
    output logic [TAG_W-1:0] out_tag,
    output logic             alu_start,
    input  logic             cmp_z,
    input  logic             cmp_n,
    output logic             illegal
);

    typedef enum logic [1:0] {IDLE, ISSUE, MC} state_t;

    state_t           state, state_n;
    logic [6:0]       op_q, op_n;
    logic [TAG_W-1:0] tag_q, tag_n;
    logic [3:0]       cnt, cnt_n;
    logic             start_q, start_n;
    logic             z_q, n_q, z_n, n_n;

    logic       accept;
    logic [5:0] dec_aluop;
    logic       dec_imm, dec_wb, dec_rd, dec_wr, dec_br, dec_rt, dec_take;
    logic       dec_legal, dec_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            cnt     <= '0;
            start_q <= 1'b0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state   <= state_n;
            op_q    <= op_n;
            tag_q   <= tag_n;
            cnt     <= cnt_n;
            start_q <= start_n;
            z_q     <= z_n;
            n_q     <= n_n;
        end
    end

    // Decode of the registered opcode; branch conditions use the flag
    // register, which already holds the result of a compare issued last cycle.
    always_comb begin
        dec_aluop = 6'd0;
        dec_imm   = 1'b0;
        dec_wb    = 1'b0;
        dec_rd    = 1'b0;
        dec_wr    = 1'b0;
        dec_br    = 1'b0;
        dec_rt    = 1'b0;
        dec_take  = 1'b0;
        dec_legal = 1'b1;
        dec_stall = 1'b0;
        case (op_q)
            7'h00, 7'h01: begin dec_aluop = 6'd0;  dec_wb = 1'b1; end
            7'h02, 7'h03: begin dec_aluop = 6'd1;  dec_wb = 1'b1; end
            7'h04, 7'h05: begin dec_aluop = 6'd2;  dec_wb = 1'b1; end
            7'h06, 7'h07: begin dec_aluop = 6'd3;  dec_wb = 1'b1; end
            7'h08, 7'h09: dec_aluop = 6'd4;
            7'h0A:        begin dec_aluop = 6'd5;  dec_wb = 1'b1; end
            7'h0B, 7'h0C: begin dec_aluop = 6'd6;  dec_wb = 1'b1; end
            7'h0D, 7'h0E: begin dec_aluop = 6'd7;  dec_wb = 1'b1; end
            7'h0F, 7'h10: begin dec_aluop = 6'd8;  dec_wb = 1'b1; end
            7'h11, 7'h12: begin dec_aluop = 6'd9;  dec_wb = 1'b1; end
            7'h13, 7'h14: begin dec_aluop = 6'd10; dec_wb = 1'b1; end
            7'h15, 7'h16: begin dec_aluop = 6'd11; dec_wb = 1'b1; end
            7'h17:        begin dec_aluop = 6'd12; dec_wb = 1'b1; dec_rd = 1'b1; end
            7'h18:        begin dec_aluop = 6'd13; dec_wr = 1'b1; end
            7'h7F:        begin dec_legal = 1'b0; dec_stall = 1'b1; end
            default:      dec_legal = (op_q <= 7'h26);
        endcase
        case (op_q)
            7'h01, 7'h03, 7'h05, 7'h07, 7'h09, 7'h0C,
            7'h0E, 7'h10, 7'h12, 7'h14, 7'h16: dec_imm = 1'b1;
            default: ;
        endcase
        // Branches alternate immediate-target (odd) and register-target (even).
        if (op_q >= 7'h19 && op_q <= 7'h26) begin
            dec_br    = 1'b1;
            dec_rt    = ~op_q[0];
            dec_aluop = op_q[0] ? 6'd14 : 6'd15;
            case (op_q)
                7'h19, 7'h1A: dec_take = 1'b1;
                7'h1B, 7'h1C: dec_take = z_q;
                7'h1D, 7'h1E: dec_take = ~z_q;
                7'h1F, 7'h20: dec_take = ~z_q & ~n_q;
                7'h21, 7'h22: dec_take = ~n_q;
                7'h23, 7'h24: dec_take = n_q;
                default:      dec_take = n_q | z_q;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state != MC) || (cnt == 4'd0);
        accept    = in_valid && in_ready;
        out_valid = ((state == ISSUE) && dec_legal) || ((state == MC) && (cnt == 4'd0));
        illegal   = (state == ISSUE) && !dec_legal && !dec_stall;
        alu_start = (state == MC) && start_q;

        out_aluop       = out_valid ? dec_aluop : 6'd0;
        out_use_imm     = out_valid && dec_imm;
        out_wb_en       = out_valid && dec_wb;
        out_mem_rd      = out_valid && dec_rd;
        out_mem_wr      = out_valid && dec_wr;
        out_is_branch   = out_valid && dec_br;
        out_reg_target  = out_valid && dec_rt;
        out_take_branch = out_valid && dec_take;
        out_tag         = out_valid ? tag_q : '0;

        state_n = state;
        op_n    = op_q;
        tag_n   = tag_q;
        cnt_n   = cnt;
        start_n = 1'b0;
        z_n     = z_q;
        n_n     = n_q;

        if (out_valid && (dec_aluop == 6'd4)) begin
            z_n = cmp_z;
            n_n = cmp_n;
        end

        if (state == ISSUE || (state == MC && cnt == 4'd0)) begin
            state_n = IDLE;
        end else if (state == MC) begin
            cnt_n = cnt - 4'd1;
        end

        // A new accept may coincide with the completion of the previous op.
        if (accept) begin
            op_n  = in_opcode;
            tag_n = in_tag;
            if (in_opcode[6:2] == 5'b00001) begin
                state_n = MC;
                start_n = 1'b1;
                cnt_n   = in_opcode[1] ? 4'(DIV_LAT - 1) : 4'(MUL_LAT - 1);
            end else begin
                state_n = ISSUE;
            end
        end
    end

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// tb/tb_exec_issue_ctrl.sv - scoreboard testbench for exec_issue_ctrl
module tb_exec_issue_ctrl;

    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 8;
    localparam int TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [6:0]       in_opcode = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic [5:0]       out_aluop;
    logic             out_use_imm, out_wb_en, out_mem_rd, out_mem_wr;
    logic             out_is_branch, out_reg_target, out_take_branch;
    logic [TAG_W-1:0] out_tag;
    logic             alu_start;
    logic             cmp_z = 1'b0;
    logic             cmp_n = 1'b0;
    logic             illegal;

    exec_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_tag(in_tag),
        .out_valid(out_valid), .out_aluop(out_aluop),
        .out_use_imm(out_use_imm), .out_wb_en(out_wb_en),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_is_branch(out_is_branch), .out_reg_target(out_reg_target),
        .out_take_branch(out_take_branch), .out_tag(out_tag),
        .alu_start(alu_start), .cmp_z(cmp_z), .cmp_n(cmp_n),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             v;
        logic             ill;
        logic [5:0]       aluop;
        logic             imm, wb, rd, wr, br, rt, take;
        logic [TAG_W-1:0] tag;
    } res_t;

    typedef struct {
        int   cyc;
        res_t r;
    } ent_t;

    ent_t sbq[$];
    int   startq[$];
    int   cyc = 0;
    int   mc_lo = 1;
    int   mc_hi = 0;
    logic mz = 1'b0;
    logic mn = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference decode built from the opcode/aluop tables.
    function automatic res_t model(input logic [6:0] op, input logic [TAG_W-1:0] tag);
        res_t r;
        r = '0;
        if (op > 7'h26) begin
            r.ill = 1'b1;
            return r;
        end
        r.v   = 1'b1;
        r.tag = tag;
        case (op)
            7'h00, 7'h01: r.aluop = 6'd0;
            7'h02, 7'h03: r.aluop = 6'd1;
            7'h04, 7'h05: r.aluop = 6'd2;
            7'h06, 7'h07: r.aluop = 6'd3;
            7'h08, 7'h09: r.aluop = 6'd4;
            7'h0A:        r.aluop = 6'd5;
            7'h0B, 7'h0C: r.aluop = 6'd6;
            7'h0D, 7'h0E: r.aluop = 6'd7;
            7'h0F, 7'h10: r.aluop = 6'd8;
            7'h11, 7'h12: r.aluop = 6'd9;
            7'h13, 7'h14: r.aluop = 6'd10;
            7'h15, 7'h16: r.aluop = 6'd11;
            7'h17:        r.aluop = 6'd12;
            7'h18:        r.aluop = 6'd13;
            7'h19, 7'h1B, 7'h1D, 7'h1F, 7'h21, 7'h23, 7'h25: r.aluop = 6'd14;
            default:      r.aluop = 6'd15;
        endcase
        r.imm = op inside {7'h01, 7'h03, 7'h05, 7'h07, 7'h09, 7'h0C, 7'h0E,
                           7'h10, 7'h12, 7'h14, 7'h16};
        r.wb  = (op <= 7'h17) && !(op inside {7'h08, 7'h09});
        r.rd  = (op == 7'h17);
        r.wr  = (op == 7'h18);
        r.br  = (op >= 7'h19);
        r.rt  = op inside {7'h1A, 7'h1C, 7'h1E, 7'h20, 7'h22, 7'h24, 7'h26};
        case (op)
            7'h19, 7'h1A: r.take = 1'b1;
            7'h1B, 7'h1C: r.take = mz;
            7'h1D, 7'h1E: r.take = !mz;
            7'h1F, 7'h20: r.take = !mz && !mn;
            7'h21, 7'h22: r.take = !mn;
            7'h23, 7'h24: r.take = mn;
            7'h25, 7'h26: r.take = mn || mz;
            default:      r.take = 1'b0;
        endcase
        return r;
    endfunction

    // Drives one instruction after the clock edge; the accept happens at the
    // end of the current cycle because in_ready is already settled.
    task automatic send(input logic [6:0] op, input logic [TAG_W-1:0] tag);
        int   w;
        int   lat;
        ent_t e;
        @(posedge clk); #1;
        w = 0;
        while (!in_ready && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        in_valid  = 1'b1;
        in_opcode = op;
        in_tag    = tag;
        lat = (op == 7'h04 || op == 7'h05) ? MUL_LAT :
              (op == 7'h06 || op == 7'h07) ? DIV_LAT : 1;
        if (op != 7'h7F) begin
            e.cyc = cyc + lat;
            e.r   = model(op, tag);
            sbq.push_back(e);
        end
        if (lat > 1) begin
            startq.push_back(cyc + 1);
            mc_lo = cyc + 1;
            mc_hi = cyc + lat - 1;
        end
        if (op == 7'h08 || op == 7'h09) begin
            mz = cmp_z;
            mn = cmp_n;
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic do_reset();
        res_t z;
        @(posedge clk); #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        sbq.delete();
        startq.delete();
        mc_lo = 1;
        mc_hi = 0;
        mz    = 1'b0;
        mn    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        z = '{v: out_valid, ill: illegal, aluop: out_aluop, imm: out_use_imm,
              wb: out_wb_en, rd: out_mem_rd, wr: out_mem_wr, br: out_is_branch,
              rt: out_reg_target, take: out_take_branch, tag: out_tag};
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_alu_start", 32'(alu_start), 0);
        check("rst_outputs", 32'(z), 0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            res_t got;
            ent_t e;
            check("in_ready", 32'(in_ready), 32'(!(cyc >= mc_lo && cyc <= mc_hi)));
            if (startq.size() > 0 && startq[0] == cyc) begin
                void'(startq.pop_front());
                check("alu_start", 32'(alu_start), 1);
            end else if (alu_start) begin
                check("alu_start_spurious", 32'(alu_start), 0);
            end
            if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                check("missing_out", 32'(e.cyc), 32'(cyc));
            end
            if (out_valid || illegal) begin
                got = '{v: out_valid, ill: illegal, aluop: out_aluop, imm: out_use_imm,
                        wb: out_wb_en, rd: out_mem_rd, wr: out_mem_wr, br: out_is_branch,
                        rt: out_reg_target, take: out_take_branch, tag: out_tag};
                if (sbq.size() == 0) begin
                    check("unexpected_out", 32'(got), 0);
                end else begin
                    e = sbq.pop_front();
                    check("out_cycle", 32'(cyc), 32'(e.cyc));
                    check("out_fields", 32'(got), 32'(e.r));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        send(7'h1D, 5'd1);                       // BNE after reset: Z=0, taken
        send(7'h01, 5'd3);                       // ADDI
        send(7'h0B, 5'd4);                       // AND
        send(7'h13, 5'd5);                       // LSR
        send(7'h18, 5'd6);                       // STR
        idle(2);
        send(7'h04, 5'd7);                       // MUL
        send(7'h00, 5'd8);                       // ADD issues the cycle after MUL done
        send(7'h07, 5'd9);                       // DIVI
        idle(10);
        cmp_z = 1'b1; cmp_n = 1'b0;
        send(7'h08, 5'd10);                      // CMP
        send(7'h1B, 5'd11);                      // BEQ   -> taken
        send(7'h24, 5'd12);                      // BRLT  -> not taken
        send(7'h25, 5'd13);                      // BLE   -> taken
        cmp_z = 1'b0; cmp_n = 1'b1;
        send(7'h09, 5'd14);                      // CMPI
        send(7'h21, 5'd15);                      // BGE   -> not taken
        send(7'h7F, 5'd16);                      // STALL: nothing issued
        send(7'h30, 5'd17);                      // illegal
        send(7'h23, 5'd18);                      // BLT: N still 1 -> taken
        send(7'h1E, 5'd31);                      // BRNE: Z=0 -> taken
        send(7'h17, 5'd20);                      // LDR
        send(7'h16, 5'd21);                      // MOVI
        send(7'h0A, 5'd22);                      // NOT
        send(7'h05, 5'd23);                      // MULI
        idle(6);
        send(7'h06, 5'd24);                      // DIV, then reset in its 4th MC cycle
        idle(1);
        repeat (2) @(posedge clk);
        do_reset();
        idle(12);
        send(7'h02, 5'd25);                      // SUB after reset
        send(7'h1F, 5'd26);                      // BGT with cleared flags -> taken
        idle(6);
        check("drain_out", 32'(sbq.size()), 0);
        check("drain_start", 32'(startq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
